ifmap_pop_scheduler: RTL and testbench
======================================

IFMAP_POP_SCHEDULER -- requirements
Module: ifmap_pop_scheduler

Interface
REQ-001 SHALL have parameter NUM_IFMAP_FIFO, default 32, giving the number of ifmap FIFO lanes.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of each pop-count input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ifmap_need_pop_i  input  NUM_IFMAP_FIFO  per-lane request to start a pop burst.
REQ-006 SHALL have port ifmap_pop_num_i  input  NUM_IFMAP_FIFO x CNT_W  per-lane pop count, sampled with ifmap_need_pop_i.
REQ-007 SHALL have port clear_i  input  1  returns all lanes to IDLE.
REQ-008 SHALL have port fifo_empty_i  input  NUM_IFMAP_FIFO  per-lane ifmap FIFO empty flag.
REQ-009 SHALL have port pe_ready_i  input  NUM_IFMAP_FIFO  per-lane PE row ready to accept data.
REQ-010 SHALL have port fifo_pop_o  output  NUM_IFMAP_FIFO  per-lane pop strobe to the ifmap FIFO.
REQ-011 SHALL have port ifmap_fifo_done_matrix_o  output  NUM_IFMAP_FIFO  per-lane burst-complete flag.
REQ-012 SHALL have port busy_o  output  1  at least one lane in POP.
REQ-013 SHALL have port all_done_o  output  1  every lane in DONE.

Function
REQ-014 SHALL run an independent three-state machine per lane: IDLE, POP, DONE.
REQ-015 IDLE -> POP SHALL occur when ifmap_need_pop_i[k]=1 and ifmap_pop_num_i[k]!=0: load remaining count = ifmap_pop_num_i[k].
REQ-016 IDLE -> DONE SHALL occur when ifmap_need_pop_i[k]=1 and ifmap_pop_num_i[k]=0, with no pop issued.
REQ-017 In POP, fifo_pop_o[k] SHALL be combinational: fifo_empty_i[k]=0 AND pe_ready_i[k]=1 AND clear_i=0; zero latency.
REQ-018 Each asserted fifo_pop_o[k] SHALL decrement the remaining count by exactly 1 at the next edge.
REQ-019 POP -> DONE SHALL occur on the edge where a pop happens with remaining count = 1; exactly ifmap_pop_num_i[k] pops total.
REQ-020 While fifo empty or PE not ready, a POP lane SHALL stall, holding its count, with no timeout.
REQ-021 ifmap_need_pop_i[k] SHALL be ignored in POP and DONE.
REQ-022 DONE SHALL hold (done bit = 1) until clear_i.
REQ-023 clear_i=1 SHALL force every lane to IDLE at the next edge, aborting POP bursts; it suppresses fifo_pop_o in the same cycle and takes priority over a simultaneous ifmap_need_pop_i.
REQ-024 ifmap_fifo_done_matrix_o[k] SHALL equal (lane k state == DONE), registered.
REQ-025 busy_o SHALL be OR over lanes of (state==POP); all_done_o SHALL be AND of ifmap_fifo_done_matrix_o.
REQ-026 The remaining count SHALL be CNT_W wide and SHALL never wrap below 0.

Reset
REQ-027 rst=1 at a clock edge SHALL put every lane in IDLE with count 0, taking priority over clear_i and requests.
REQ-028 Reset values SHALL be: fifo_pop_o=0, ifmap_fifo_done_matrix_o=0, busy_o=0, all_done_o=0.
REQ-029 Reset asserted mid-burst SHALL abort all lanes with no further pops after the reset edge.

Structure
REQ-030 The lane state enum and the NUM_IFMAP_FIFO default SHALL live in shared package token_engine_pkg.
REQ-031 The per-lane FSM plus counter SHALL be sub-module ifmap_pop_lane, instantiated NUM_IFMAP_FIFO times by generate; the top holds only the reductions.

Verification
REQ-032 Pointwise: all 32 lanes need_pop=1, pop_num=1, FIFOs non-empty, ready=1 -> one pop per lane in cycle 1; done_matrix=FFFF_FFFF and all_done=1 one cycle later.
REQ-033 Depthwise: lanes 0..29 pop_num=3*(k/3+1), lanes 30..31 pop_num=0 -> lane 29 issues 30 pops; lanes 30..31 done after 1 cycle; all_done after 30 pop cycles.
REQ-034 Stall: lane 0 pop_num=4, fifo_empty toggles every other cycle -> exactly 4 pops, none while empty; done after the 4th.
REQ-035 Abort: clear_i during lane 5 burst (2 of 6 pops done) -> pop_o=0 that cycle; IDLE next; a new need_pop restarts from a full count.
REQ-036 Same-cycle: clear_i and need_pop together -> lane stays IDLE; rst during a burst -> all outputs 0 after the edge.

Source files
------------

// File: rtl/token_engine_pkg.sv
// rtl/token_engine_pkg.sv - shared types and defaults for the ifmap pop scheduler
package token_engine_pkg;

  // Lane default count for the ifmap FIFO array
  localparam int NUM_IFMAP_FIFO_DEF = 32;

  // Per-lane burst state
  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_POP  = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

endpackage

// File: rtl/ifmap_pop_lane.sv
// rtl/ifmap_pop_lane.sv - one ifmap FIFO lane: IDLE/POP/DONE burst FSM with remaining-pop counter
module ifmap_pop_lane
  import token_engine_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             need_pop,
  input  logic [CNT_W-1:0] pop_num,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic             pe_ready,
  output logic             pop,
  output logic             done,
  output logic             busy
);

  lane_state_e      state;
  logic [CNT_W-1:0] remaining;

  // Pop strobe is combinational so a ready FIFO/PE pair moves a word in the same cycle;
  // clear kills it immediately so an aborted burst never issues a trailing pop.
  assign pop  = (state == LANE_POP) && !fifo_empty && pe_ready && !clear;
  assign done = (state == LANE_DONE);
  assign busy = (state == LANE_POP);

  // Burst FSM: reset beats clear, clear beats requests; the counter only moves on a real pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LANE_IDLE;
      remaining <= '0;
    end else if (clear) begin
      state     <= LANE_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        LANE_IDLE: begin
          if (need_pop) begin
            if (pop_num != '0) begin
              state     <= LANE_POP;
              remaining <= pop_num;
            end else begin
              state     <= LANE_DONE;
              remaining <= '0;
            end
          end
        end
        LANE_POP: begin
          if (pop) begin
            // Last word of the burst; the <= also keeps the counter from ever wrapping.
            if (remaining <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state     <= LANE_DONE;
              remaining <= '0;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        LANE_DONE: begin
          state <= LANE_DONE;
        end
        default: begin
          state     <= LANE_IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ifmap_pop_scheduler.sv
// rtl/ifmap_pop_scheduler.sv - array of independent ifmap pop lanes plus busy/all-done reductions
module ifmap_pop_scheduler
  import token_engine_pkg::*;
#(
  parameter int NUM_IFMAP_FIFO = NUM_IFMAP_FIFO_DEF,
  parameter int CNT_W          = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_IFMAP_FIFO-1:0]       ifmap_need_pop_i,
  input  logic [NUM_IFMAP_FIFO*CNT_W-1:0] ifmap_pop_num_i,
  input  logic                            clear_i,
  input  logic [NUM_IFMAP_FIFO-1:0]       fifo_empty_i,
  input  logic [NUM_IFMAP_FIFO-1:0]       pe_ready_i,
  output logic [NUM_IFMAP_FIFO-1:0]       fifo_pop_o,
  output logic [NUM_IFMAP_FIFO-1:0]       ifmap_fifo_done_matrix_o,
  output logic                            busy_o,
  output logic                            all_done_o
);

  logic [NUM_IFMAP_FIFO-1:0] lane_busy;

  // One self-contained FSM per lane; lanes never interact
  for (genvar k = 0; k < NUM_IFMAP_FIFO; k++) begin : g_lane
    ifmap_pop_lane #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .need_pop   (ifmap_need_pop_i[k]),
      .pop_num    (ifmap_pop_num_i[k*CNT_W +: CNT_W]),
      .clear      (clear_i),
      .fifo_empty (fifo_empty_i[k]),
      .pe_ready   (pe_ready_i[k]),
      .pop        (fifo_pop_o[k]),
      .done       (ifmap_fifo_done_matrix_o[k]),
      .busy       (lane_busy[k])
    );
  end

  assign busy_o     = |lane_busy;
  assign all_done_o = &ifmap_fifo_done_matrix_o;

endmodule

// File: tb/tb_ifmap_pop_scheduler.sv
// tb/tb_ifmap_pop_scheduler.sv - directed self-checking bench for ifmap_pop_scheduler
module tb_ifmap_pop_scheduler;

  localparam int N = 32;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   need;
  logic [N*W-1:0] num;
  logic           clear;
  logic [N-1:0]   empty;
  logic [N-1:0]   ready;
  logic [N-1:0]   pop;
  logic [N-1:0]   done;
  logic           busy;
  logic           all_done;

  int n_vec  = 0;
  int n_miss = 0;

  ifmap_pop_scheduler #(
    .NUM_IFMAP_FIFO (N),
    .CNT_W          (W)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .ifmap_need_pop_i         (need),
    .ifmap_pop_num_i          (num),
    .clear_i                  (clear),
    .fifo_empty_i             (empty),
    .pe_ready_i               (ready),
    .fifo_pop_o               (pop),
    .ifmap_fifo_done_matrix_o (done),
    .busy_o                   (busy),
    .all_done_o               (all_done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_num(input int k, input logic [W-1:0] v);
    num[k*W +: W] = v;
  endtask

  task automatic do_clear();
    need  = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
  endtask

  int c0, c15, c29, c5, cyc, viol, i;

  initial begin
    rst   = 1'b1;
    need  = '0;
    num   = '0;
    clear = 1'b0;
    empty = '0;
    ready = '1;
    tick();
    tick();
    check("rst_pop", pop, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_alldone", all_done, 0);
    rst = 1'b0;
    #1;

    // Pointwise: every lane pops exactly once
    for (int k = 0; k < N; k++) set_num(k, 1);
    need = '1;
    #1;
    check("pw_pop_idle", pop, 0);
    tick();
    need = '0;
    #1;
    check("pw_pop_c1", pop, 32'hFFFF_FFFF);
    check("pw_busy", busy, 1);
    tick();
    check("pw_done", done, 32'hFFFF_FFFF);
    check("pw_alldone", all_done, 1);
    check("pw_pop_after", pop, 0);
    check("pw_busy_after", busy, 0);
    do_clear();
    check("pw_clear_done", done, 0);

    // Depthwise: lane k pops 3*(k/3+1), lanes 30..31 request zero pops
    for (int k = 0; k < 30; k++) set_num(k, 3 * (k / 3 + 1));
    set_num(30, 0);
    set_num(31, 0);
    need = '1;
    tick();
    need = '0;
    #1;
    check("dw_zero_done", done, 32'hC000_0000);
    check("dw_busy", busy, 1);
    c0 = 0; c15 = 0; c29 = 0; cyc = 0;
    for (i = 1; i <= 100; i++) begin
      c0  += int'(pop[0]);
      c15 += int'(pop[15]);
      c29 += int'(pop[29]);
      tick();
      if (all_done) begin
        cyc = i;
        break;
      end
    end
    check("dw_cycles", cyc, 30);
    check("dw_lane0", c0, 3);
    check("dw_lane15", c15, 18);
    check("dw_lane29", c29, 30);
    check("dw_done_all", done, 32'hFFFF_FFFF);
    check("dw_pop_after", pop, 0);
    do_clear();

    // Stall: lane 0 with FIFO empty every other cycle
    for (int k = 0; k < N; k++) set_num(k, 0);
    set_num(0, 4);
    need = 32'h1;
    tick();
    need = '0;
    c0 = 0; viol = 0; cyc = 0;
    for (i = 0; i < 40; i++) begin
      empty[0] = i[0];
      #1;
      if (empty[0] && pop[0]) viol++;
      c0 += int'(pop[0]);
      tick();
      if (done[0]) begin
        cyc = i;
        break;
      end
    end
    empty = '0;
    check("st_pops", c0, 4);
    check("st_viol", viol, 0);
    check("st_cycle", cyc, 6);
    check("st_done", done, 32'h1);
    check("st_alldone", all_done, 0);
    // PE-not-ready also stalls a lane
    do_clear();
    set_num(0, 1);
    need = 32'h1;
    ready[0] = 1'b0;
    tick();
    need = '0;
    tick();
    tick();
    check("st_ready_hold", {busy, pop[0], done[0]}, 3'b100);
    ready[0] = 1'b1;
    tick();
    check("st_ready_done", done, 32'h1);
    do_clear();

    // Abort: clear lane 5 after 2 of 6 pops, then restart with full count
    set_num(0, 0);
    set_num(5, 6);
    need = 32'h20;
    tick();
    need = '0;
    tick();
    tick();
    clear = 1'b1;
    #1;
    check("ab_pop_sup", pop, 0);
    check("ab_busy", busy, 1);
    tick();
    clear = 1'b0;
    #1;
    check("ab_idle_busy", busy, 0);
    check("ab_idle_done", done, 0);
    need = 32'h20;
    tick();
    need = '0;
    c5 = 0;
    for (i = 0; i < 20; i++) begin
      c5 += int'(pop[5]);
      tick();
      if (done[5]) break;
    end
    check("ab_restart_pops", c5, 6);
    check("ab_restart_done", done, 32'h20);
    do_clear();

    // Same-cycle clear and request: clear wins
    set_num(3, 2);
    need  = 32'h8;
    clear = 1'b1;
    tick();
    need  = '0;
    clear = 1'b0;
    #1;
    check("sc_busy", busy, 0);
    check("sc_done", done, 0);
    check("sc_pop", pop, 0);

    // Reset during a burst aborts every lane
    for (int k = 0; k < N; k++) set_num(k, 5);
    need = '1;
    tick();
    need = '0;
    tick();
    #1;
    check("rb_mid_pop", pop, 32'hFFFF_FFFF);
    rst  = 1'b1;
    need = '1;
    tick();
    check("rb_pop", pop, 0);
    check("rb_done", done, 0);
    check("rb_busy", busy, 0);
    check("rb_alldone", all_done, 0);
    rst  = 1'b0;
    need = '0;
    tick();
    check("rb_post_pop", pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
